// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: reset vector, FSM states
// and the IF/ID hand-off record.
package fetch_unit_pkg;

  localparam int unsigned INSTR_W          = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;

  typedef enum logic [0:0] {
    S_REQ,
    S_WAIT
  } fetch_state_e;

  typedef struct packed {
    logic               valid;
    logic [31:0]        pc;
    logic [31:0]        pc_plus4;
    logic [INSTR_W-1:0] instr;
    logic               adel;
  } if_id_t;

  // Sequential PC increment; wraps modulo 2^32 without any flag.
  function automatic logic [31:0] pc_inc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_out_buf.sv
// One-entry IF/ID output register with valid/ready consumption and flush.
// Flush clears valid and the address-error flag; the other fields hold.
module fetch_out_buf
  import fetch_unit_pkg::*;
(
  input  logic   clk,
  input  logic   resetn,
  input  logic   flush,
  input  logic   load,
  input  if_id_t load_entry,
  input  logic   ready,
  output if_id_t entry
);

  if_id_t entry_q, entry_d;

  always_comb begin
    entry_d = entry_q;
    if (flush) begin
      entry_d.valid = 1'b0;
      entry_d.adel  = 1'b0;
    end else if (load) begin
      entry_d = load_entry;
    end else if (entry_q.valid && ready) begin
      entry_d.valid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      entry_q <= '0;
    end else begin
      entry_q <= entry_d;
    end
  end

  assign entry = entry_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, single-outstanding memory request FSM,
// redirect handling and the IF/ID output buffer.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [31:0]       imem_rdata,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [ADDR_W-1:0] if_pc,
  output logic [ADDR_W-1:0] if_pc_plus4,
  output logic [31:0]       if_instr,
  output logic              if_adel
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] inflight_q, inflight_d;
  logic              drop_q, drop_d;

  logic   buf_free;
  logic   pc_aligned;
  logic   req;
  logic   buf_load;
  if_id_t load_entry;
  if_id_t out_entry;

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_PC;
      inflight_q <= '0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
    end
  end

  // Next-state logic; a redirect overrides everything else.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    inflight_d = inflight_q;
    drop_d     = drop_q;
    if (redirect_valid) begin
      pc_d = redirect_pc;
      if (state_q == S_WAIT) begin
        if (imem_rvalid) begin
          state_d = S_REQ;
          drop_d  = 1'b0;
        end else begin
          drop_d = 1'b1;
        end
      end
    end else begin
      unique case (state_q)
        S_REQ: begin
          if (req && imem_gnt) begin
            state_d    = S_WAIT;
            inflight_d = pc_q;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            if (!drop_q) pc_d = pc_inc(pc_q);
            drop_d  = 1'b0;
            state_d = S_REQ;
          end
        end
        default: state_d = S_REQ;
      endcase
    end
  end

  // Outputs and buffer load selection
  always_comb begin
    buf_free   = !out_entry.valid || if_ready;
    pc_aligned = (pc_q[1:0] == 2'b00);
    req        = resetn && (state_q == S_REQ) && buf_free && pc_aligned && !redirect_valid;
    buf_load   = 1'b0;
    load_entry = '0;
    if (!redirect_valid) begin
      if (state_q == S_REQ && !pc_aligned && buf_free) begin
        // Misaligned fetch: no memory access, hand an AdEL entry to decode.
        buf_load            = 1'b1;
        load_entry.valid    = 1'b1;
        load_entry.pc       = pc_q;
        load_entry.pc_plus4 = pc_inc(pc_q);
        load_entry.instr    = '0;
        load_entry.adel     = 1'b1;
      end else if (state_q == S_WAIT && imem_rvalid && !drop_q) begin
        buf_load            = 1'b1;
        load_entry.valid    = 1'b1;
        load_entry.pc       = inflight_q;
        load_entry.pc_plus4 = pc_inc(inflight_q);
        load_entry.instr    = imem_rdata;
        load_entry.adel     = 1'b0;
      end
    end
  end

  fetch_out_buf u_out_buf (
    .clk        (clk),
    .resetn     (resetn),
    .flush      (redirect_valid),
    .load       (buf_load),
    .load_entry (load_entry),
    .ready      (if_ready),
    .entry      (out_entry)
  );

  assign imem_req    = req;
  assign imem_addr   = pc_q;
  assign if_valid    = out_entry.valid;
  assign if_pc       = out_entry.pc;
  assign if_pc_plus4 = out_entry.pc_plus4;
  assign if_instr    = out_entry.instr;
  assign if_adel     = out_entry.adel;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by random
// traffic, all checked against a transaction-level model of the fetch stage.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        resetn;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic [31:0] if_instr;
  logic        if_adel;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: what the fetch stage should hold at any moment.
  logic [31:0] m_pc;
  bit          m_busy;
  logic [31:0] m_inflight;
  bit          m_drop;
  bit          m_v;
  logic [31:0] m_pc_o, m_p4, m_ins;
  bit          m_adel;

  fetch_unit #(
    .ADDR_W   (32),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk            (clk),
    .resetn         (resetn),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_pc_plus4    (if_pc_plus4),
    .if_instr       (if_instr),
    .if_adel        (if_adel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check request side, clock, update model, check IF/ID side.
  task automatic step(input bit rst_n, input bit redir, input logic [31:0] rpc, input bit rdy,
                      input bit rv, input logic [31:0] rd, input bit g);
    bit free;
    bit exp_req;
    resetn         = rst_n;
    redirect_valid = redir;
    redirect_pc    = rpc;
    if_ready       = rdy;
    imem_rvalid    = rv;
    imem_rdata     = rd;
    imem_gnt       = g;
    free    = !m_v || rdy;
    exp_req = rst_n && !m_busy && free && (m_pc[1:0] == 2'b00) && !redir;
    #1;
    chk("imem_req", 32'(imem_req), 32'(exp_req));
    if (rst_n) chk("imem_addr", imem_addr, m_pc);
    @(posedge clk);
    if (!rst_n) begin
      m_pc = RESET_PC; m_busy = 0; m_drop = 0; m_inflight = '0;
      m_v = 0; m_pc_o = '0; m_p4 = '0; m_ins = '0; m_adel = 0;
    end else begin
      if (m_v && rdy) m_v = 0;
      if (redir) begin
        if (m_busy) begin
          if (rv) begin m_busy = 0; m_drop = 0; end
          else m_drop = 1;
        end
        m_pc = rpc; m_v = 0; m_adel = 0;
      end else if (!m_busy) begin
        if (exp_req && g) begin
          m_busy = 1; m_inflight = m_pc;
        end else if (m_pc[1:0] != 2'b00 && free) begin
          m_v = 1; m_pc_o = m_pc; m_p4 = m_pc + 32'd4; m_ins = '0; m_adel = 1;
        end
      end else if (rv) begin
        if (!m_drop) begin
          m_v = 1; m_pc_o = m_inflight; m_p4 = m_inflight + 32'd4; m_ins = rd; m_adel = 0;
          m_pc = m_pc + 32'd4;
        end
        m_busy = 0; m_drop = 0;
      end
    end
    #1;
    chk("if_valid", 32'(if_valid), 32'(m_v));
    chk("if_pc", if_pc, m_pc_o);
    chk("if_pc_plus4", if_pc_plus4, m_p4);
    chk("if_instr", if_instr, m_ins);
    chk("if_adel", 32'(if_adel), 32'(m_adel));
  endtask

  initial begin
    bit          r_rst, r_redir, r_rdy, r_rv, r_g;
    logic [31:0] r_pc;
    m_pc = RESET_PC; m_busy = 0; m_drop = 0; m_inflight = '0;
    m_v = 0; m_pc_o = '0; m_p4 = '0; m_ins = '0; m_adel = 0;

    // Reset
    step(0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    chk("rst_if_valid", 32'(if_valid), 32'd0);

    // Back-to-back fetch at full rate
    step(1, 0, 0, 1, 0, 32'h1111_0000, 1);
    step(1, 0, 0, 1, 1, 32'h1111_0000, 0);
    chk("t1_if_pc0", if_pc, 32'hBFC0_0000);
    chk("t1_addr1", imem_addr, 32'hBFC0_0004);
    step(1, 0, 0, 1, 0, 0, 1);
    step(1, 0, 0, 1, 1, 32'h1111_0004, 0);
    step(1, 0, 0, 1, 0, 0, 1);
    step(1, 0, 0, 1, 1, 32'h1111_0008, 0);
    chk("t1_if_pc2", if_pc, 32'hBFC0_0008);
    chk("t1_if_pc4", if_pc_plus4, 32'hBFC0_000C);

    // Decode stall holds the buffer and blocks requests
    step(1, 0, 0, 1, 0, 0, 1);
    step(1, 0, 0, 0, 1, 32'h2408_0001, 0);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0, 0, 1);
    chk("t2_instr", if_instr, 32'h2408_0001);
    step(1, 0, 0, 1, 0, 0, 1);
    step(1, 0, 0, 1, 1, 32'h1111_0010, 0);

    // Redirect while waiting: the late response is dropped
    step(1, 0, 0, 1, 0, 0, 1);
    step(1, 1, 32'h8000_0100, 1, 0, 0, 0);
    step(1, 0, 0, 1, 0, 0, 0);
    step(1, 0, 0, 1, 1, 32'hDEAD_BEEF, 0);
    chk("t3_dropped", 32'(if_valid), 32'd0);
    chk("t3_addr", imem_addr, 32'h8000_0100);
    step(1, 0, 0, 1, 0, 0, 1);
    step(1, 0, 0, 1, 1, 32'h2222_0100, 0);

    // Redirect coincident with the response
    step(1, 0, 0, 1, 0, 0, 1);
    step(1, 1, 32'h8000_0200, 1, 1, 32'h3333_3333, 0);
    chk("t4_addr", imem_addr, 32'h8000_0200);
    step(1, 0, 0, 1, 0, 0, 1);
    step(1, 0, 0, 1, 1, 32'hAAAA_0200, 0);
    chk("t4_if_pc", if_pc, 32'h8000_0200);

    // Misaligned target raises AdEL without a memory access
    step(1, 1, 32'h0000_0102, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 1);
    chk("t5_adel", 32'(if_adel), 32'd1);
    chk("t5_pc", if_pc, 32'h0000_0102);
    step(1, 0, 0, 0, 0, 0, 1);
    step(1, 1, 32'hBFC0_0380, 0, 0, 0, 0);
    step(1, 0, 0, 1, 0, 0, 1);
    step(1, 0, 0, 1, 1, 32'h4444_0380, 0);
    chk("t5_exc_pc", if_pc, 32'hBFC0_0380);

    // PC wrap, then reset with a fetch outstanding
    step(1, 1, 32'hFFFF_FFFC, 1, 0, 0, 0);
    step(1, 0, 0, 1, 0, 0, 1);
    step(1, 0, 0, 1, 1, 32'h5555_FFFC, 0);
    chk("t6_wrap", imem_addr, 32'h0000_0000);
    step(1, 0, 0, 1, 0, 0, 1);
    step(0, 0, 0, 1, 0, 0, 0);
    step(1, 0, 0, 1, 1, 32'h6666_6666, 0);
    chk("t6_rst_addr", imem_addr, RESET_PC);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      r_rst   = ($urandom_range(0, 99) >= 2);
      r_redir = ($urandom_range(0, 99) < 10);
      r_pc    = $urandom;
      if ($urandom_range(0, 3) != 0) r_pc[1:0] = 2'b00;
      r_rdy   = ($urandom_range(0, 99) < 70);
      r_rv    = m_busy ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 99) < 5);
      r_g     = ($urandom_range(0, 1) == 1);
      step(r_rst, r_redir, r_pc, r_rdy, r_rv, $urandom, r_g);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage of the 50-instruction MIPS core.
- Owns the program counter, generates PC+4 and issues single-outstanding requests to instruction memory.
- Registers the returned instruction with its PC into the IF/ID hand-off using a valid/ready interface.
- Accepts redirects from branch/jump/exception logic downstream.

Parameters:
- RESET_PC, 32'hBFC0_0000, PC value after reset.
- ADDR_W, 32, width of PC and memory address (fixed at 32 for this core).

Ports:
- clk  in  1  core clock, rising edge.
- resetn  in  1  synchronous active-low reset.
- redirect_valid  in  1  one-cycle pulse to load a new PC (branch/jump/jr/exception, already prioritised upstream).
- redirect_pc  in  32  target PC for the redirect.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address; always equals the PC register.
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  read data valid; at most one response per granted request, earliest the cycle after gnt.
- imem_rdata  in  32  instruction word.
- if_valid  out  1  IF/ID output holds an instruction.
- if_ready  in  1  decode accepts; low means a hazard-unit stall.
- if_pc  out  32  PC of the held instruction.
- if_pc_plus4  out  32  if_pc + 4, used by link/branch logic.
- if_instr  out  32  held instruction word.
- if_adel  out  1  address-error-on-fetch flag for the held entry.

Behaviour:
- Clocking/reset: single clock; synchronous active-low reset (resetn). All state updates occur on the rising edge of clk.
- Reset values: pc=RESET_PC, state=S_REQ, drop=0, if_valid=0, if_pc=0, if_pc_plus4=0, if_instr=0, if_adel=0. imem_req is held 0 while resetn=0.
- Arithmetic: pc_next_seq = pc + 32'd4, computed modulo 2^32. 32'hFFFF_FFFC wraps to 32'h0000_0000 with no flag.
- Output buffer is "free" when if_valid=0, or when if_valid=1 and if_ready=1 in the same cycle.
- FSM S_REQ:
  - imem_req = free & (pc[1:0]==0) & ~redirect_valid.
  - req & gnt -> latch pc into inflight_pc, go to S_WAIT.
  - req held with a stable address until gnt.
  - Misaligned pc with free buffer -> no memory request. Load the buffer with if_valid=1, if_pc=pc, if_instr=0, if_adel=1. pc holds (the exception redirect moves it); stay in S_REQ.
- FSM S_WAIT:
  - imem_req=0.
  - rvalid & ~drop -> next cycle if_valid=1, if_pc=inflight_pc, if_pc_plus4=inflight_pc+4, if_instr=rdata, if_adel=0. pc <= pc+4; go to S_REQ.
  - rvalid & drop -> discard data, clear drop, go to S_REQ.
- Handshake guarantee: an instruction is only requested when the buffer is free, so rvalid never arrives with the buffer occupied and unconsumed.
- Consumption: if_valid & if_ready with no new load -> if_valid <= 0. Buffer contents are stable while if_valid=1 and if_ready=0.
- Redirect (highest priority, any state):
  - pc <= redirect_pc; if_valid <= 0 (flush); if_adel <= 0.
  - In S_WAIT without rvalid that cycle -> drop <= 1.
  - In S_WAIT with rvalid the same cycle -> data discarded, go to S_REQ, drop stays 0.
  - In S_REQ with gnt the same cycle cannot occur, because req is gated by ~redirect_valid.
  - Latency: imem_addr shows redirect_pc the cycle after the pulse.
- Latency: gnt at cycle N, rvalid at N+1 -> if_valid at N+2. Peak throughput is 1 instruction per 2 cycles.
- Stray inputs: rvalid while in S_REQ is ignored. gnt while req=0 is ignored.
- Reset mid-fetch: state returns to S_REQ, drop=0, outstanding response ignored, buffer flushed.

Decomposition:
- Shared core package holds:
  - RESET_PC default and INSTR_W=32.
  - fetch_state_e enum {S_REQ, S_WAIT}.
  - if_id_t struct {valid, pc, pc_plus4, instr, adel} for the IF/ID bus.
- One natural sub-module: fetch_out_buf, the one-entry valid/ready output register with flush, loaded from either the memory response or the address-error path.
- FSM and PC register stay in fetch_unit.

Test Plan:
- Reset release, gnt same cycle as req, rvalid 1 cycle later, if_ready=1 -> imem_addr sequence BFC0_0000, BFC0_0004, BFC0_0008. if_pc matches each with a 2-cycle lag; if_pc_plus4 = if_pc+4.
- Stall: hold if_ready=0 for 5 cycles with an instruction 0x2408_0001 buffered -> if_* stable, imem_req=0 throughout. Release -> next request for pc+4 issues the same cycle.
- Redirect in S_WAIT to 0x8000_0100, rvalid 2 cycles later carrying 0xDEAD_BEEF -> word discarded, if_valid stays 0. Next req addr 0x8000_0100.
- Redirect and rvalid in the same cycle -> word discarded. imem_addr = redirect_pc next cycle; no drop of the following response.
- Redirect to 0x0000_0102 -> no imem_req. if_valid=1, if_adel=1, if_pc=0x0000_0102, if_instr=0. A following redirect to 0xBFC0_0380 flushes it and fetches from 0xBFC0_0380.
- Wrap, plus reset during S_WAIT: pc=0xFFFF_FFFC -> next address 0x0000_0000. Assert resetn=0 during S_WAIT, then deliver a late rvalid -> it is ignored, and the first request after release is at RESET_PC.
